// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: boot-time program load, then sequential fetch with redirect.
// Loader is built only when IMEM_FETCH_CTRL_LOADER_EN is defined; otherwise memory is preloaded.
module imem_fetch_ctrl #(
    parameter int          DEPTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int         AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid,
    input  logic [31:0]   load_data,
    input  logic          load_last,
    output logic          load_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr,
    output logic [31:0]   pc_out,
    output logic          halted
);

    typedef enum logic [1:0] {S_LOAD, S_FETCH, S_HALT} state_t;

`ifdef IMEM_FETCH_CTRL_LOADER_EN
    localparam state_t RESET_STATE = S_LOAD;
`else
    localparam state_t RESET_STATE = S_FETCH;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q, halted_d;
    logic        capture_opp;
    logic        pc_out_of_range;
    logic        unused_pc_lsb;

    // A new word may enter the output register when it is empty or being drained.
    assign capture_opp     = !instr_valid_q || instr_ready;
    // DEPTH is a power of two, so any set bit above the word index is past the end.
    assign pc_out_of_range = |pc_q[31:AW+2];
    assign unused_pc_lsb   = ^redirect_pc[1:0];

    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign halted      = halted_q;

`ifdef IMEM_FETCH_CTRL_LOADER_EN
    logic [AW-1:0] lptr_q, lptr_d;

    assign load_ready = (state_q == S_LOAD);
    assign imem_we    = load_ready && load_valid;
    assign imem_waddr = lptr_q;
    assign imem_wdata = load_data;
`else
    logic unused_load;

    assign load_ready  = 1'b0;
    assign imem_we     = 1'b0;
    assign imem_waddr  = '0;
    assign imem_wdata  = '0;
    assign unused_load = ^{load_valid, load_last, load_data};
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
`ifdef IMEM_FETCH_CTRL_LOADER_EN
        lptr_d        = lptr_q;
`endif
        if (redirect && state_q != S_LOAD) begin
            // Flush wins over any capture or consumption in the same cycle.
            instr_valid_d = 1'b0;
            pc_d          = {redirect_pc[31:2], 2'b00};
            halted_d      = 1'b0;
            state_d       = S_FETCH;
        end else begin
            case (state_q)
`ifdef IMEM_FETCH_CTRL_LOADER_EN
                S_LOAD: begin
                    if (load_valid) begin
                        lptr_d = lptr_q + 1'b1;
                        if (load_last || (&lptr_q)) begin
                            state_d = S_FETCH;
                            pc_d    = RESET_PC;
                            lptr_d  = '0;
                        end
                    end
                end
`endif
                S_FETCH: begin
                    if (capture_opp) begin
                        if (pc_out_of_range) begin
                            state_d       = S_HALT;
                            halted_d      = 1'b1;
                            instr_valid_d = 1'b0;
                        end else begin
                            instr_d       = imem_rdata;
                            pc_out_d      = pc_q;
                            instr_valid_d = 1'b1;
                            pc_d          = pc_q + 32'd4;
                        end
                    end
                end
                S_HALT: begin
                    if (instr_valid_q && instr_ready) begin
                        instr_valid_d = 1'b0;
                    end
                end
                default: state_d = RESET_STATE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RESET_STATE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            pc_out_q      <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
`ifdef IMEM_FETCH_CTRL_LOADER_EN
            lptr_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
`ifdef IMEM_FETCH_CTRL_LOADER_EN
            lptr_q        <= lptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: memory model plus scoreboard of expected (pc, instr) fetches.
module tb_imem_fetch_ctrl;

    localparam int          DEPTH    = 32;
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IMEM_FETCH_CTRL_LOADER_EN
    localparam bit LOADER = 1'b1;
`else
    localparam bit LOADER = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          load_valid;
    logic [31:0]   load_data;
    logic          load_last;
    logic          load_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [31:0]   pc_out;
    logic          halted;

    int   total = 0;
    int   bad   = 0;
    int   we_seen = 0;
    exp_t exp_q[$];
    exp_t e;
    logic [31:0] prog     [DEPTH];
    logic [31:0] exp_mem  [DEPTH];
    logic [31:0] init_val [DEPTH];
    logic [31:0] mem      [DEPTH];
    logic        fill_req;

    imem_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc_out(pc_out), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: combinational read, write on the clock edge.
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val[i];
        end else if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end
    assign imem_rdata = mem[imem_addr[AW+1:2]];

    always @(posedge clk) if (imem_we && rst_n) we_seen <= we_seen + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", instr); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc_out got=%h want=0", pc_out); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
        total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr got=%h want=%h", imem_addr, RESET_PC); end
        total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", imem_we); end
        total++; if (load_ready !== LOADER) begin bad++; $display("FAIL reset_load_ready got=%b want=%b", load_ready, LOADER); end
    endtask

    task automatic test_start();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL start_valid got=%b want=1", instr_valid); end
        total++; if (pc_out !== RESET_PC) begin bad++; $display("FAIL start_pc_out got=%h want=%h", pc_out, RESET_PC); end
        total++; if (instr !== exp_mem[0]) begin bad++; $display("FAIL start_instr got=%h want=%h", instr, exp_mem[0]); end
        total++; if (imem_addr !== RESET_PC + 32'd4) begin bad++; $display("FAIL start_addr got=%h want=%h", imem_addr, RESET_PC + 32'd4); end
    endtask

    task automatic test_load3();
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            load_valid = 1'b1; load_data = prog[k]; load_last = (k == 2);
            exp_mem[k] = prog[k];
            #1;
            total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL load_ready got=%b want=1", load_ready); end
            total++; if (imem_we !== 1'b1) begin bad++; $display("FAIL load_we got=%b want=1", imem_we); end
            total++; if (imem_waddr !== AW'(k)) begin bad++; $display("FAIL load_waddr got=%0d want=%0d", imem_waddr, k); end
            total++; if (imem_wdata !== prog[k]) begin bad++; $display("FAIL load_wdata got=%h want=%h", imem_wdata, prog[k]); end
            $display("load idx=%0d data=%h", k, prog[k]);
        end
        @(negedge clk); load_valid = 1'b0; load_last = 1'b0; #1;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL load_exit_ready got=%b want=0", load_ready); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL load_exit_valid got=%b want=0", instr_valid); end
        total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL load_exit_addr got=%h want=%h", imem_addr, RESET_PC); end
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL load_first_valid got=%b want=1", instr_valid); end
        total++; if (pc_out !== RESET_PC) begin bad++; $display("FAIL load_first_pc got=%h want=%h", pc_out, RESET_PC); end
        total++; if (instr !== prog[0]) begin bad++; $display("FAIL load_first_instr got=%h want=%h", instr, prog[0]); end
    endtask

    task automatic test_fetch_stall();
        logic [5:0] rdy_pat;
        rdy_pat = 6'b110001;
        exp_q.push_back('{pc: 32'h0, ins: exp_mem[0]});
        exp_q.push_back('{pc: 32'h4, ins: exp_mem[1]});
        exp_q.push_back('{pc: 32'h8, ins: exp_mem[2]});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); instr_ready = rdy_pat[c]; #1;
            if (!instr_ready) begin
                total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", instr_valid); end
                total++; if (pc_out !== 32'h4) begin bad++; $display("FAIL stall_pc_out got=%h want=4", pc_out); end
                total++; if (instr !== exp_mem[1]) begin bad++; $display("FAIL stall_instr got=%h want=%h", instr, exp_mem[1]); end
                total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL stall_addr got=%h want=8", imem_addr); end
            end else if (instr_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL stall_sb_extra got pc=%h want=none", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_out !== e.pc || instr !== e.ins) begin
                        bad++; $display("FAIL stall_sb got pc=%h instr=%h want pc=%h instr=%h", pc_out, instr, e.pc, e.ins);
                    end else $display("fetch pc=%h instr=%h", pc_out, instr);
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_sb_left got=%0d want=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_redirect();
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h0000_000E; instr_ready = 1'b1; #1;
        total++; if (pc_out !== 32'hC) begin bad++; $display("FAIL redir_pre_pc got=%h want=c", pc_out); end
        @(negedge clk); redirect = 1'b0; instr_ready = 1'b0; #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b want=0", instr_valid); end
        total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL redir_addr got=%h want=c", imem_addr); end
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL redir_valid got=%b want=1", instr_valid); end
        total++; if (pc_out !== 32'hC) begin bad++; $display("FAIL redir_pc_out got=%h want=c", pc_out); end
        total++; if (instr !== exp_mem[3]) begin bad++; $display("FAIL redir_instr got=%h want=%h", instr, exp_mem[3]); end
    endtask

    task automatic test_halt();
        if (LOADER) begin
            @(negedge clk); rst_n = 1'b0;
            @(negedge clk); rst_n = 1'b1;
            for (int k = 0; k < DEPTH; k++) begin
                @(negedge clk);
                load_valid = 1'b1; load_data = prog[k]; load_last = 1'b0;
                exp_mem[k] = prog[k];
                #1;
                total++; if (imem_we !== 1'b1 || imem_waddr !== AW'(k)) begin
                    bad++; $display("FAIL auto_load got we=%b idx=%0d want we=1 idx=%0d", imem_we, imem_waddr, k);
                end
            end
            @(negedge clk); load_valid = 1'b0; #1;
            total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL auto_exit got=%b want=0", load_ready); end
        end else begin
            @(negedge clk); redirect = 1'b1; redirect_pc = 32'h0;
            @(negedge clk); redirect = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('{pc: 32'(i) * 32'd4, ins: exp_mem[i]});
        instr_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); #1;
            if (instr_valid && instr_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL halt_sb_extra got pc=%h want=none", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_out !== e.pc || instr !== e.ins) begin
                        bad++; $display("FAIL halt_sb got pc=%h instr=%h want pc=%h instr=%h", pc_out, instr, e.pc, e.ins);
                    end else $display("fetch pc=%h instr=%h", pc_out, instr);
                end
            end
            if (exp_q.size() == 0) break;
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL halt_sb_timeout got=%0d want=0", exp_q.size()); end
        exp_q.delete();
        @(negedge clk); #1;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b want=1", halted); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL halt_valid got=%b want=0", instr_valid); end
        total++; if (imem_addr !== 32'h80) begin bad++; $display("FAIL halt_addr got=%h want=80", imem_addr); end
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h10; instr_ready = 1'b0; #1;
        @(negedge clk); redirect = 1'b0; #1;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL resume_halted got=%b want=0", halted); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL resume_flush got=%b want=0", instr_valid); end
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b1 || pc_out !== 32'h10) begin
            bad++; $display("FAIL resume_fetch got valid=%b pc=%h want valid=1 pc=10", instr_valid, pc_out);
        end
        total++; if (instr !== exp_mem[4]) begin bad++; $display("FAIL resume_instr got=%h want=%h", instr, exp_mem[4]); end
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h1000_0004; #1;
        @(negedge clk); redirect = 1'b0; #1;
        total++; if (halted !== 1'b0 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL oor_flush got halted=%b valid=%b want 0 0", halted, instr_valid);
        end
        total++; if (imem_addr !== 32'h1000_0004) begin bad++; $display("FAIL oor_addr got=%h want=10000004", imem_addr); end
        @(negedge clk); #1;
        total++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL oor_halt got halted=%b valid=%b want 1 0", halted, instr_valid);
        end
    endtask

    task automatic test_reset_mid();
        if (LOADER) begin
            @(negedge clk); rst_n = 1'b0;
            @(negedge clk); rst_n = 1'b1;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk); load_valid = 1'b1; load_data = prog[k]; load_last = 1'b0; #1;
                total++; if (imem_waddr !== AW'(k)) begin bad++; $display("FAIL mid_waddr got=%0d want=%0d", imem_waddr, k); end
            end
            @(negedge clk); load_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL mid_halted got=%b want=0", halted); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", instr_valid); end
        total++; if (pc_out !== 32'h0 || instr !== 32'h0) begin
            bad++; $display("FAIL mid_regs got pc=%h instr=%h want 0 0", pc_out, instr);
        end
        total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL mid_addr got=%h want=%h", imem_addr, RESET_PC); end
        total++; if (load_ready !== LOADER) begin bad++; $display("FAIL mid_load_ready got=%b want=%b", load_ready, LOADER); end
        @(negedge clk); rst_n = 1'b1;
        if (LOADER) begin
            @(negedge clk); load_valid = 1'b1; load_data = prog[0]; #1;
            total++; if (load_ready !== 1'b1 || imem_waddr !== '0) begin
                bad++; $display("FAIL mid_restart got ready=%b idx=%0d want ready=1 idx=0", load_ready, imem_waddr);
            end
            @(negedge clk); load_valid = 1'b0;
        end else begin
            @(negedge clk); #1;
            total++; if (instr_valid !== 1'b1 || pc_out !== RESET_PC || instr !== exp_mem[0]) begin
                bad++; $display("FAIL mid_refetch got valid=%b pc=%h instr=%h want 1 %h %h", instr_valid, pc_out, instr, RESET_PC, exp_mem[0]);
            end
            total++; if (we_seen != 0) begin bad++; $display("FAIL no_write got=%0d want=0", we_seen); end
        end
    endtask

    initial begin
        rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) prog[i] = 32'hA000_0000 + 32'(i) * 32'h101;
        prog[0] = 32'h2008_0005;
        prog[1] = 32'h2009_0003;
        prog[2] = 32'h0109_5020;
        for (int i = 0; i < DEPTH; i++) begin
            init_val[i] = LOADER ? (32'hDEAD_0000 | 32'(i)) : prog[i];
            exp_mem[i]  = init_val[i];
        end
        fill_req = 1'b1;
        @(negedge clk); fill_req = 1'b0;

        test_reset();
        if (LOADER) test_load3();
        else        test_start();
        test_fetch_stall();
        test_redirect();
        test_halt();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Sequencer for the word-addressed instruction memory. After reset it writes a program into the memory from a valid/ready load stream. It then fetches sequentially from the program counter into a registered instruction output with a valid/ready handshake to decode, and supports branch/jump redirects. It sits between the boot/load source, the instruction memory's read and write ports, and the decode stage.

## Interface
- `DEPTH`, 32: instruction memory size in 32-bit words; must be a power of two.
- `RESET_PC`, 32'h0000_0000: first fetch byte address after load/reset.
- `AW`, $clog2(DEPTH): word-index width (derived, not overridden).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_valid` in 1: load word present.
- `load_data` in 32: program word.
- `load_last` in 1: qualifies final load word.
- `load_ready` out 1: loader accepts a word this cycle.
- `imem_we` out 1: memory write strobe.
- `imem_waddr` out AW: memory write word index.
- `imem_wdata` out 32: memory write data.
- `imem_addr` out 32: memory read byte address; equals internal PC.
- `imem_rdata` in 32: combinational read data for `imem_addr`.
- `redirect` in 1: flush and jump.
- `redirect_pc` in 32: jump target byte address.
- `instr_valid` out 1: `instr`/`pc_out` hold a valid fetch.
- `instr_ready` in 1: decode consumes the instruction.
- `instr` out 32: fetched instruction.
- `pc_out` out 32: byte address of `instr`.
- `halted` out 1: PC has run past the end of memory.

## Operation
- States: LOAD, FETCH, HALT.
- Reset values:
  - state=LOAD; PC=RESET_PC; load pointer=0.
  - `instr_valid`=0; `instr`=0; `pc_out`=0; `halted`=0.
- **LOAD**
  - `load_ready`=1.
  - `imem_we`=`load_valid`; `imem_waddr`=load pointer; `imem_wdata`=`load_data`.
  - Each accepted word increments the pointer.
  - Transition to FETCH after the accepted word that has `load_last`=1, or after the word written at index DEPTH-1, whichever comes first.
  - PC=RESET_PC on exit.
  - `redirect` is ignored in LOAD.
- **FETCH**
  - `load_ready`=0; `imem_we`=0.
  - Capture occurs when `instr_valid`=0 or `instr_ready`=1.
  - On capture: `instr`←`imem_rdata`, `pc_out`←PC, `instr_valid`←1, PC←PC+4 (32-bit wrap).
  - Without capture: `instr`/`pc_out` hold; `instr_valid` stays 1.
  - If PC[31:2] ≥ DEPTH at a capture opportunity: no capture, go to HALT, `halted`←1.
  - `instr_valid` clears when the last held word is consumed.
- **HALT**
  - No fetch.
  - A consumed word clears `instr_valid`.
  - `redirect` returns to FETCH.
- **Redirect** (FETCH or HALT), highest priority:
  - `instr_valid`←0; PC←{`redirect_pc`[31:2],2'b00}; `halted`←0; state←FETCH.
  - No capture that cycle, even if `instr_ready`=1.
  - A target that is out of range halts at the next capture opportunity.
- Reset asserted mid-operation aborts immediately: all state returns to reset values. Partially loaded memory contents are left as is.

## Timing
- `imem_addr` is combinational from the PC register. The read completes in the same cycle.
- Fetch latency: the first `instr_valid`=1 comes 1 cycle after entering FETCH. The first instruction after a redirect also appears 1 cycle after the redirect.
- Throughput: 1 instruction/cycle while `instr_ready`=1.
- Load: 1 word/cycle. The memory write happens on the same edge as the handshake.

## Configuration
- `IMEM_FETCH_CTRL_LOADER_EN`
- Defined: LOAD state present as described.
- Undefined:
  - Reset enters FETCH directly; the first instruction is valid in the cycle after `rst_n` deasserts.
  - `load_ready`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0; load inputs are ignored.
  - The memory is preloaded from file.

## Test plan
- Load words 0x20080005, 0x20090003, 0x01095020, with `load_last` on the third → writes at indices 0,1,2. FETCH then yields `pc_out` 0x0, 0x4, 0x8 on consecutive cycles with matching `instr`.
- Hold `instr_ready`=0 for 3 cycles while `pc_out`=0x4 → `instr`/`pc_out` stable, `instr_valid`=1, `imem_addr` stays 0x8.
- `redirect`=1, `redirect_pc`=0x0000000E, with `instr_ready`=1 in the same cycle → next cycle `instr_valid`=0. The following cycle gives `pc_out`=0xC.
- Stream 32 words without `load_last` → automatic FETCH after index 31. The fetch runs 0x0..0x7C, then `halted`=1 and `instr_valid` drops after the 0x7C word is consumed. A redirect to 0x10 resumes fetch.
- Assert `rst_n`=0 after 2 of 5 load words → outputs return to reset values, the load pointer restarts at 0, and `load_ready`=1 after release.
- Build without `IMEM_FETCH_CTRL_LOADER_EN` → `instr_valid`=1 with `pc_out`=RESET_PC one cycle after reset release; `imem_we` never asserts.
